// File: rtl/fifo_rd_packer_pkg.sv
// Shared defaults and helpers for the FIFO read-side packer.
package fifo_pkg;

   localparam int unsigned DSIZE_DEF = 8;
   localparam int unsigned RATIO_DEF = 4;

   // Width of one packed output beat.
   function automatic int unsigned beat_width(int unsigned dsize, int unsigned ratio);
      return dsize * ratio;
   endfunction

   // Low n bits set: the word-keep mask for a beat holding n words (ratio up to 31).
   function automatic logic [31:0] keep_mask(int unsigned n);
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Valid/ready beat stream from the packer toward the rendering pipeline.
interface fifo_rd_packer_if #(
   parameter int unsigned DSIZE = fifo_pkg::DSIZE_DEF,
   parameter int unsigned RATIO = fifo_pkg::RATIO_DEF
);

   logic                                          m_valid;
   logic                                          m_ready;
   logic [fifo_pkg::beat_width(DSIZE, RATIO)-1:0] m_data;
   logic [RATIO-1:0]                              m_keep;
   logic                                          m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_keep,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_keep,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/fifo_rd_packer_out_reg.sv
// Single-entry valid/ready output register: loads a beat, holds it while stalled.
module stream_out_reg
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_DEF,
   parameter int unsigned RATIO = RATIO_DEF
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                load,
   input  logic [beat_width(DSIZE, RATIO)-1:0] ld_data,
   input  logic [RATIO-1:0]                    ld_keep,
   input  logic                                ld_last,
   output logic                                out_free,
   fifo_rd_packer_if.master                    m
);

   // A new beat may enter when the register is empty or draining this cycle.
   assign out_free = !m.m_valid || m.m_ready;

   // Load wins over a transfer so back-to-back beats keep m_valid high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m.m_valid <= 1'b0;
         m.m_data  <= '0;
         m.m_keep  <= '0;
         m.m_last  <= 1'b0;
      end else if (load) begin
         m.m_valid <= 1'b1;
         m.m_data  <= ld_data;
         m.m_keep  <= ld_keep;
         m.m_last  <= ld_last;
      end else if (m.m_ready) begin
         m.m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops words from a fall-through FIFO and packs RATIO of them per output beat;
// a flush request closes a partial beat with a keep mask.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_DEF,
   parameter int unsigned RATIO = RATIO_DEF
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   input  logic             flush,
   output logic             flush_done,
   fifo_rd_packer_if.master m
);

   localparam int unsigned IDXW = $clog2(RATIO);
   localparam int unsigned BW   = beat_width(DSIZE, RATIO);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RATIO - 1);

   logic [IDXW-1:0]  idx;
   logic [DSIZE-1:0] acc [RATIO-1];
   logic             out_free;
   logic             flush_take;
   logic             at_last;
   logic             load;
   logic [BW-1:0]    ld_data;
   logic [RATIO-1:0] ld_keep;
   logic             ld_last;

   assign at_last    = (idx == IDX_LAST);
   // flush_done high means the current request was just served; ignore it once.
   assign flush_take = flush && out_free && !flush_done;
   // The last word of a beat can only be popped when the output register can take it.
   assign rinc       = rrst_n && !rempty && !flush_take && (!at_last || out_free);
   assign load       = (rinc && at_last) || (flush_take && (idx != '0));

   // Beat assembly: full beat is {rdata, acc}; a flushed beat zeroes unfilled words.
   always_comb begin
      ld_keep = flush_take ? RATIO'(keep_mask(32'(idx))) : '1;
      ld_last = flush_take;
      ld_data = '0;
      for (int i = 0; i < RATIO - 1; i++) begin
         ld_data[i*DSIZE +: DSIZE] = ld_keep[i] ? acc[i] : '0;
      end
      ld_data[BW-1 -: DSIZE] = flush_take ? '0 : rdata;
   end

   // Accumulator fill and flush acknowledge.
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         idx        <= '0;
         flush_done <= 1'b0;
         for (int i = 0; i < RATIO - 1; i++) begin
            acc[i] <= '0;
         end
      end else begin
         flush_done <= flush_take;
         if (flush_take) begin
            idx <= '0;
         end else if (rinc) begin
            if (at_last) begin
               idx <= '0;
            end else begin
               acc[idx] <= rdata;
               idx      <= idx + IDXW'(1);
            end
         end
      end
   end

   stream_out_reg #(
      .DSIZE (DSIZE),
      .RATIO (RATIO)
   ) u_out_reg (
      .clk      (rclk),
      .rst_n    (rrst_n),
      .load     (load),
      .ld_data  (ld_data),
      .ld_keep  (ld_keep),
      .ld_last  (ld_last),
      .out_free (out_free),
      .m        (m)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: a queue-based FIFO source, a word-list
// reference model checked every cycle, a flush vector table and directed corners.
module tb_fifo_rd_packer;

   localparam int unsigned DSIZE = 8;
   localparam int unsigned RATIO = 4;

   logic       rclk = 1'b0;
   logic       rrst_n;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic       flush;
   logic       flush_done;

   fifo_rd_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) bus ();

   fifo_rd_packer #(
      .DSIZE (DSIZE),
      .RATIO (RATIO)
   ) dut (
      .rclk       (rclk),
      .rrst_n     (rrst_n),
      .rempty     (rempty),
      .rdata      (rdata),
      .rinc       (rinc),
      .flush      (flush),
      .flush_done (flush_done),
      .m          (bus)
   );

   always #5 rclk = ~rclk;

   int checks = 0;
   int errors = 0;

   // FIFO source contents and a control that forces the FIFO to look empty.
   logic [7:0] src_q[$];
   bit         hold_empty = 1'b0;

   // Reference model: words waiting for a beat plus the expected output register.
   logic [7:0]  m_pend[$];
   logic        e_valid = 1'b0;
   logic [31:0] e_data  = '0;
   logic [3:0]  e_keep  = '0;
   logic        e_last  = 1'b0;
   logic        e_fd    = 1'b0;
   logic        last_rinc;

   typedef struct {
      int          n;
      logic [31:0] words;
      logic        exp_beat;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;
   } flush_vec_t;

   flush_vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_pend();
      logic [31:0] d = '0;
      for (int i = 0; i < m_pend.size(); i++) d = d | (32'(m_pend[i]) << (8 * i));
      return d;
   endfunction

   // One clock: drive FIFO head, check rinc, advance model, check registered outputs.
   task automatic cycle();
      logic       r_exp, of, ft;
      logic [7:0] rd_s;
      rempty = hold_empty || (src_q.size() == 0);
      rdata  = (src_q.size() != 0) ? src_q[0] : 8'h00;
      #1;
      of    = !e_valid || bus.m_ready;
      ft    = flush && of && !e_fd;
      r_exp = rrst_n && !rempty && !ft && ((m_pend.size() != RATIO - 1) || of);
      chk("rinc", rinc, r_exp);
      last_rinc = rinc;
      rd_s = rdata;
      @(posedge rclk);
      if (last_rinc && src_q.size() != 0) void'(src_q.pop_front());
      if (!rrst_n) begin
         m_pend.delete();
         e_valid = 0; e_data = '0; e_keep = '0; e_last = 0; e_fd = 0;
      end else begin
         if (e_valid && bus.m_ready) e_valid = 0;
         if (ft) begin
            if (m_pend.size() > 0) begin
               e_data  = pack_pend();
               e_keep  = 4'((1 << m_pend.size()) - 1);
               e_last  = 1;
               e_valid = 1;
               m_pend.delete();
            end
         end else if (r_exp) begin
            m_pend.push_back(rd_s);
            if (m_pend.size() == RATIO) begin
               e_data  = pack_pend();
               e_keep  = 4'hF;
               e_last  = 0;
               e_valid = 1;
               m_pend.delete();
            end
         end
         e_fd = ft;
      end
      #1;
      chk("m_valid", bus.m_valid, e_valid);
      chk("flush_done", flush_done, e_fd);
      if (e_valid) begin
         chk("m_data", bus.m_data, e_data);
         chk("m_keep", bus.m_keep, e_keep);
         chk("m_last", bus.m_last, e_last);
      end
   endtask

   task automatic push(input logic [7:0] w);
      src_q.push_back(w);
   endtask

   initial begin
      logic        got, seen;
      logic [31:0] gd;
      logic [3:0]  gk;
      logic        gl;
      int          fd_cnt;

      vecs[0] = '{0, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0000};
      vecs[1] = '{1, 32'h0000_00AA, 1'b1, 32'h0000_00AA, 4'b0001};
      vecs[2] = '{2, 32'h0000_BBAA, 1'b1, 32'h0000_BBAA, 4'b0011};
      vecs[3] = '{3, 32'h00CC_BBAA, 1'b1, 32'h00CC_BBAA, 4'b0111};
      vecs[4] = '{2, 32'h0000_5AC3, 1'b1, 32'h0000_5AC3, 4'b0011};

      rrst_n = 0; flush = 0; bus.m_ready = 1; rempty = 1; rdata = '0;

      // Reset with a non-empty FIFO: no pops, clean outputs.
      for (int i = 0; i < 4; i++) push(8'(i + 1));
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rst_rinc", last_rinc, 0);
      end
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_data", bus.m_data, 0);
      chk("rst_keep", bus.m_keep, 0);
      chk("rst_last", bus.m_last, 0);
      chk("rst_fd", flush_done, 0);
      src_q.delete();
      rrst_n = 1;
      cycle();

      // Flush table: n words then a held flush request.
      for (int v = 0; v < 5; v++) begin
         flush = 0; bus.m_ready = 1;
         for (int i = 0; i < vecs[v].n; i++) push(vecs[v].words[8*i +: 8]);
         for (int i = 0; i < vecs[v].n; i++) cycle();
         flush = 1; got = 0; seen = 0; fd_cnt = 0; gd = '0; gk = '0; gl = 0;
         for (int k = 0; k < 6; k++) begin
            cycle();
            if (bus.m_valid && !got) begin
               got = 1; gd = bus.m_data; gk = bus.m_keep; gl = bus.m_last;
            end
            if (flush_done) fd_cnt++;
            if (seen) flush = 0;
            if (flush_done) seen = 1;
         end
         flush = 0;
         chk("tbl_beat", got, vecs[v].exp_beat);
         if (vecs[v].exp_beat) begin
            chk("tbl_data", gd, vecs[v].exp_data);
            chk("tbl_keep", gk, vecs[v].exp_keep);
            chk("tbl_last", gl, 1);
         end
         chk("tbl_fd_cnt", fd_cnt, 1);
      end

      // Streaming: eight back-to-back pops, two full beats.
      bus.m_ready = 1;
      for (int i = 0; i < 8; i++) push(8'(8'h11 * (i + 1)));
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("stream_rinc", last_rinc, 1);
         if (i == 3 || i == 7) begin
            chk("stream_valid", bus.m_valid, 1);
            chk("stream_data", bus.m_data, (i == 3) ? 32'h4433_2211 : 32'h8877_6655);
            chk("stream_keep", bus.m_keep, 4'hF);
            chk("stream_last", bus.m_last, 0);
         end
      end
      cycle();
      chk("stream_drain", bus.m_valid, 0);

      // Backpressure at a full accumulator.
      for (int i = 0; i < 4; i++) push(8'(8'h11 * (i + 1)));
      for (int i = 0; i < 4; i++) cycle();
      chk("bp_first", bus.m_data, 32'h4433_2211);
      bus.m_ready = 0;
      for (int i = 4; i < 8; i++) push(8'(8'h11 * (i + 1)));
      for (int i = 0; i < 3; i++) cycle();
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("bp_rinc", last_rinc, 0);
         chk("bp_hold", bus.m_data, 32'h4433_2211);
      end
      bus.m_ready = 1;
      cycle();
      chk("bp_pop", last_rinc, 1);
      chk("bp_valid", bus.m_valid, 1);
      chk("bp_data", bus.m_data, 32'h8877_6655);
      cycle();

      // Flush and pop collide at idx=1.
      push(8'hAA);
      cycle();
      push(8'hBB);
      flush = 1;
      cycle();
      chk("coll_rinc", last_rinc, 0);
      chk("coll_data", bus.m_data, 32'h0000_00AA);
      chk("coll_keep", bus.m_keep, 4'b0001);
      chk("coll_last", bus.m_last, 1);
      chk("coll_fd", flush_done, 1);
      cycle();
      chk("coll_pop", last_rinc, 1);
      flush = 0;
      push(8'hCC); push(8'hDD); push(8'hEE);
      for (int i = 0; i < 3; i++) cycle();
      chk("coll_next", bus.m_data, 32'hEEDD_CCBB);
      chk("coll_next_keep", bus.m_keep, 4'hF);
      cycle();

      // Reset mid-packet discards partial words.
      push(8'h01); push(8'h02); push(8'h03);
      for (int i = 0; i < 3; i++) cycle();
      rrst_n = 0;
      cycle();
      chk("mrst_valid", bus.m_valid, 0);
      rrst_n = 1;
      push(8'h10); push(8'h20); push(8'h30); push(8'h40);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("mrst_no_stale", bus.m_valid, 0);
      end
      cycle();
      chk("mrst_data", bus.m_data, 32'h4030_2010);
      chk("mrst_keep", bus.m_keep, 4'hF);
      cycle();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if (src_q.size() < 3 && $urandom_range(0, 1) == 1) push(8'($urandom));
         hold_empty  = ($urandom_range(0, 3) == 0);
         bus.m_ready = ($urandom_range(0, 2) != 0);
         rrst_n      = ($urandom_range(0, 299) != 0);
         if (!flush && $urandom_range(0, 15) == 0) flush = 1;
         cycle();
         if (flush_done || !rrst_n) flush = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
